// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read-channel arbiter.
package axi_arb_pkg;

  // AR-side arbitration FSM: pick a winner, then hold it until the handshake.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of a port index; a single bit even for one or two ports.
  function automatic int arb_idx_w(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Round-robin pick: first set bit of an eligibility vector at or above a
// pointer, wrapping to the lowest set bit when nothing above qualifies.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic         hi_found;
  logic         lo_found;

  // Descending scan so the last hit is the lowest index in each half.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int p = N - 1; p >= 0; p--) begin
      hi_idx   = (elig[p] && (W'(p) >= ptr)) ? W'(p) : hi_idx;
      hi_found = hi_found | (elig[p] && (W'(p) >= ptr));
      lo_idx   = elig[p] ? W'(p) : lo_idx;
      lo_found = lo_found | elig[p];
    end
  end

  // Prefer the index at/above the pointer; fall back to the wrapped one.
  always_comb begin
    idx   = hi_found ? hi_idx : lo_idx;
    found = hi_found | lo_found;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel (AR + R) among NUM_PORTS masters. AR requests
// are granted round-robin and tagged with the requester index in the ID
// MSBs; R beats are steered back by that tag with no buffering.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_BITS       = 16,
  parameter int TID_WIDTH       = 8,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTST       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_PORTS-1:0]                         s_ar_valid,
  output logic [NUM_PORTS-1:0]                         s_ar_ready,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]               s_ar_addr,
  input  logic [NUM_PORTS*BURST_LEN_WIDTH-1:0]         s_ar_len,
  input  logic [NUM_PORTS*TID_WIDTH-1:0]               s_ar_id,
  output logic                                         m_ar_valid,
  input  logic                                         m_ar_ready,
  output logic [ADDR_BITS-1:0]                         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]                   m_ar_len,
  output logic [TID_WIDTH+arb_idx_w(NUM_PORTS)-1:0]    m_ar_id,
  input  logic                                         m_r_valid,
  input  logic                                         m_r_last,
  input  logic [DATA_WIDTH-1:0]                        m_r_data,
  input  logic [TID_WIDTH+arb_idx_w(NUM_PORTS)-1:0]    m_r_id,
  output logic                                         m_r_ready,
  output logic [NUM_PORTS-1:0]                         s_r_valid,
  output logic [NUM_PORTS-1:0]                         s_r_last,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]              s_r_data,
  output logic [NUM_PORTS*TID_WIDTH-1:0]               s_r_id,
  input  logic [NUM_PORTS-1:0]                         s_r_ready,
  output logic                                         err_bad_rid
);

  localparam int IDX_W  = arb_idx_w(NUM_PORTS);
  localparam int M_ID_W = TID_WIDTH + IDX_W;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 err_bad_rid_q, err_bad_rid_d;

  logic [NUM_PORTS-1:0] elig_s;
  logic [NUM_PORTS-1:0] below_cap_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_found_s;
  logic                 ar_hs_s;
  logic [31:0]          r_idx_s;
  logic                 r_bad_s;
  logic                 r_last_hs_s;

  // A port competes only while it has room for another outstanding burst.
  always_comb begin
    elig_s = s_ar_valid & below_cap_s;
  end

  rr_pick #(
    .N (NUM_PORTS),
    .W (IDX_W)
  ) u_rr_pick (
    .elig  (elig_s),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Arbitration next-state logic and AR handshake steering.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    m_ar_valid = 1'b0;
    s_ar_ready = '0;
    ar_hs_s    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          state_d = ARB_GRANT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        // A withdrawn valid is a protocol violation upstream; keep the grant.
        m_ar_valid          = s_ar_valid[grant_q];
        s_ar_ready[grant_q] = m_ar_ready;
        if (s_ar_valid[grant_q] && m_ar_ready) begin
          ar_hs_s  = 1'b1;
          rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
          state_d  = ARB_IDLE;
        end else begin
          state_d  = ARB_GRANT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Forwarded AR payload always comes from the granted port's slice.
  always_comb begin
    m_ar_addr = s_ar_addr[grant_q*ADDR_BITS +: ADDR_BITS];
    m_ar_len  = s_ar_len[grant_q*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
    m_ar_id   = {grant_q, s_ar_id[grant_q*TID_WIDTH +: TID_WIDTH]};
  end

  // Decode the R tag; widened so out-of-range indices compare cleanly.
  always_comb begin
    r_idx_s     = 32'(m_r_id[M_ID_W-1 -: IDX_W]);
    r_bad_s     = (r_idx_s >= 32'(NUM_PORTS));
    r_last_hs_s = m_r_valid && m_r_ready && m_r_last;
  end

  // Steer R beats to the tagged port; an unknown tag is swallowed (ready=1).
  always_comb begin
    s_r_valid = '0;
    s_r_last  = '0;
    m_r_ready = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_idx_s == 32'(p)) begin
        s_r_valid[p] = m_r_valid;
        s_r_last[p]  = m_r_last;
        m_r_ready    = s_r_ready[p];
      end else begin
        s_r_valid[p] = 1'b0;
        s_r_last[p]  = 1'b0;
      end
    end
    s_r_data = {NUM_PORTS{m_r_data}};
    s_r_id   = {NUM_PORTS{m_r_id[TID_WIDTH-1:0]}};
  end

  // Sticky bad-tag flag; only reset clears it.
  always_comb begin
    err_bad_rid_d = err_bad_rid_q | (m_r_valid && r_bad_s);
    err_bad_rid   = err_bad_rid_q;
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      err_bad_rid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      err_bad_rid_q <= err_bad_rid_d;
    end
  end

  // Per-port outstanding-burst counters: +1 on AR handshake, -1 on R last.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_outst
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             inc_s, dec_s;

    // Saturating update; a decrement at zero (stale beat after reset) is ignored.
    always_comb begin
      inc_s = ar_hs_s && (grant_q == IDX_W'(p));
      dec_s = r_last_hs_s && (r_idx_s == 32'(p));
      case ({inc_s, dec_s})
        2'b10:   outst_d = (outst_q == {CNT_W{1'b1}}) ? outst_q : outst_q + CNT_W'(1);
        2'b01:   outst_d = (outst_q == '0) ? outst_q : outst_q - CNT_W'(1);
        default: outst_d = outst_q;
      endcase
      below_cap_s[p] = (outst_q < CNT_W'(MAX_OUTST));
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        outst_q <= '0;
      end else begin
        outst_q <= outst_d;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with 3 ports and a cap of 2 bursts.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s_ar_valid, s_ar_ready;
  logic [47:0] s_ar_addr;
  logic [23:0] s_ar_len, s_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [9:0]  m_ar_id;
  logic        m_r_valid, m_r_last, m_r_ready;
  logic [7:0]  m_r_data;
  logic [9:0]  m_r_id;
  logic [2:0]  s_r_valid, s_r_last, s_r_ready;
  logic [23:0] s_r_data, s_r_id;
  logic        err_bad_rid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .NUM_PORTS(3), .ADDR_BITS(16), .TID_WIDTH(8),
    .BURST_LEN_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_last(m_r_last), .m_r_data(m_r_data),
    .m_r_id(m_r_id), .m_r_ready(m_r_ready),
    .s_r_valid(s_r_valid), .s_r_last(s_r_last), .s_r_data(s_r_data),
    .s_r_id(s_r_id), .s_r_ready(s_r_ready), .err_bad_rid(err_bad_rid)
  );

  typedef struct {
    logic       vld;
    logic       lst;
    logic [9:0] id;
    logic [7:0] dat;
    logic [2:0] rdy;
    logic [2:0] exp_srv;
    logic [2:0] exp_srl;
    logic       exp_mrr;
  } rvec_t;

  rvec_t tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Entered at a drive point (posedge+1); returns at the drive point after the handshake.
  task automatic expect_grant(input int exp_port, input string nm);
    int cyc = 0;
    m_ar_ready = 1'b1;
    #1;
    while (!m_ar_valid && cyc < 8) begin
      @(posedge clk); #2;
      cyc++;
    end
    check({nm, "_valid"}, 32'(m_ar_valid), 32'd1);
    if (m_ar_valid) begin
      check({nm, "_port"}, 32'(m_ar_id[9:8]), 32'(exp_port));
      check({nm, "_sready"}, 32'(s_ar_ready), 32'd1 << exp_port);
    end
    @(posedge clk); #1;
    m_ar_ready = 1'b0;
  endtask

  task automatic no_grant(input int n, input string nm);
    int seen = 0;
    repeat (n) begin
      #1;
      if (m_ar_valid || (s_ar_ready != 3'b000)) seen++;
      @(posedge clk); #1;
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  task automatic r_last_beat(input int p);
    m_r_valid = 1'b1;
    m_r_last  = 1'b1;
    m_r_id    = {2'(p), 8'h00};
    s_r_ready = 3'b111;
    @(posedge clk); #1;
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    s_r_ready = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, {2'd0, 8'h05}, 8'ha5, 3'b001, 3'b001, 3'b000, 1'b1};
    tbl[1] = '{1'b1, 1'b1, {2'd1, 8'h33}, 8'h3c, 3'b000, 3'b010, 3'b010, 1'b0};
    tbl[2] = '{1'b1, 1'b1, {2'd2, 8'h44}, 8'hc3, 3'b100, 3'b100, 3'b100, 1'b1};
    tbl[3] = '{1'b0, 1'b1, {2'd1, 8'h12}, 8'h0f, 3'b010, 3'b000, 3'b010, 1'b1};
    tbl[4] = '{1'b1, 1'b0, {2'd2, 8'h99}, 8'hf0, 3'b011, 3'b100, 3'b000, 1'b0};

    rst = 1'b1;
    s_ar_valid = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
    m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = '0;

    // Reset state
    @(posedge clk); #2;
    check("rst_m_ar_valid", 32'(m_ar_valid), 32'd0);
    check("rst_s_ar_ready", 32'(s_ar_ready), 32'd0);
    check("rst_err", 32'(err_bad_rid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: combinational R routing
    for (int i = 0; i < 5; i++) begin
      m_r_valid = tbl[i].vld; m_r_last = tbl[i].lst; m_r_id = tbl[i].id;
      m_r_data = tbl[i].dat; s_r_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_s_r_valid", i), 32'(s_r_valid), 32'(tbl[i].exp_srv));
      check($sformatf("tbl%0d_s_r_last", i), 32'(s_r_last), 32'(tbl[i].exp_srl));
      check($sformatf("tbl%0d_m_r_ready", i), 32'(m_r_ready), 32'(tbl[i].exp_mrr));
      check($sformatf("tbl%0d_s_r_data", i), 32'(s_r_data), 32'({3{tbl[i].dat}}));
      check($sformatf("tbl%0d_s_r_id", i), 32'(s_r_id), 32'({3{tbl[i].id[7:0]}}));
      @(posedge clk); #1;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = '0;

    // Single port request and return beat
    s_ar_valid = 3'b001; s_ar_addr[15:0] = 16'h0eef; s_ar_len[7:0] = 8'h00; s_ar_id[7:0] = 8'h05;
    #1;
    check("single_same_cycle_valid", 32'(m_ar_valid), 32'd0);
    @(posedge clk); #2;
    check("single_m_ar_valid", 32'(m_ar_valid), 32'd1);
    check("single_m_ar_addr", 32'(m_ar_addr), 32'h0eef);
    check("single_m_ar_len", 32'(m_ar_len), 32'h00);
    check("single_m_ar_id", 32'(m_ar_id), 32'h005);
    check("single_sready_stall", 32'(s_ar_ready), 32'd0);
    m_ar_ready = 1'b1;
    #1;
    check("single_sready_hs", 32'(s_ar_ready), 32'b001);
    @(posedge clk); #1;
    s_ar_valid = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 10'h005; m_r_data = 8'h5a; s_r_ready = 3'b001;
    #1;
    check("single_m_ar_valid_after", 32'(m_ar_valid), 32'd0);
    check("single_r_valid", 32'(s_r_valid), 32'b001);
    check("single_r_data", 32'(s_r_data[7:0]), 32'h5a);
    check("single_r_id", 32'(s_r_id[7:0]), 32'h05);
    @(posedge clk); #1;
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = '0;

    // Restart rotation from port 0, then contention with cap 2 per port
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_ar_addr = {16'h2222, 16'h1111, 16'h0000};
    s_ar_id   = {8'h03, 8'h02, 8'h01};
    s_ar_valid = 3'b011;
    expect_grant(0, "cont0");
    expect_grant(1, "cont1");
    expect_grant(0, "cont2");
    expect_grant(1, "cont3");
    no_grant(4, "cap_both_held");

    // Free port 1 only; port 0 must stay held while port 1 is served
    r_last_beat(1);
    r_last_beat(1);
    expect_grant(1, "cap_p1_a");
    expect_grant(1, "cap_p1_b");
    no_grant(3, "cap_p0_held");
    r_last_beat(0);
    expect_grant(0, "cap_p0_released");
    s_ar_valid = '0;

    // R backpressure on port 1 during a 3-beat burst
    m_r_valid = 1'b1; m_r_last = 1'b0; m_r_id = {2'd1, 8'h21}; m_r_data = 8'hb1;
    s_r_ready = 3'b101;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bp_m_r_ready", 32'(m_r_ready), 32'd0);
      check("bp_s_r_valid", 32'(s_r_valid), 32'b010);
      check("bp_data_stable", 32'(s_r_data[15:8]), 32'hb1);
      @(posedge clk); #1;
    end
    s_r_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      m_r_data = 8'hb1 + 8'(k);
      m_r_last = (k == 2);
      #1;
      check("bp_go_m_r_ready", 32'(m_r_ready), 32'd1);
      check("bp_go_s_r_valid", 32'(s_r_valid), 32'b010);
      @(posedge clk); #1;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = '0;

    // Bad index 3 with only 3 ports
    #1;
    check("bad_err_before", 32'(err_bad_rid), 32'd0);
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = {2'd3, 8'h77}; s_r_ready = 3'b000;
    #1;
    check("bad_m_r_ready", 32'(m_r_ready), 32'd1);
    check("bad_s_r_valid", 32'(s_r_valid), 32'b000);
    check("bad_s_r_last", 32'(s_r_last), 32'b000);
    @(posedge clk); #1;
    m_r_valid = 1'b0; m_r_last = 1'b0;
    repeat (3) begin
      #1;
      check("bad_err_sticky", 32'(err_bad_rid), 32'd1);
      @(posedge clk); #1;
    end

    // Reset while a grant is pending (port 1 has 1 outstanding, port 0 has 2)
    s_ar_valid = 3'b010;
    @(posedge clk); #2;
    check("rg_pending_valid", 32'(m_ar_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("rg_m_ar_valid", 32'(m_ar_valid), 32'd0);
    check("rg_s_ar_ready", 32'(s_ar_ready), 32'd0);
    check("rg_err_cleared", 32'(err_bad_rid), 32'd0);
    rst = 1'b0;
    s_ar_valid = 3'b011;
    expect_grant(0, "rg0");
    expect_grant(1, "rg1");
    expect_grant(0, "rg2");
    expect_grant(1, "rg3");
    no_grant(3, "rg_cap");
    s_ar_valid = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
